mult8_seq_ctrl: RTL and testbench



---
 rtl/mult8_seq_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult8_seq_ctrl
//
// Sequential 8x8 unsigned shift-add multiplier. One shared 8-bit
// carry-lookahead adder (CLA8) is reused once per cycle for eight cycles
// instead of building an array of eight adders.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   synchronous, active-high reset
//   start  in   1   multiply request, only honoured in IDLE
//   A      in   8   multiplicand, captured on the accepting edge
//   B      in   8   multiplier, captured on the accepting edge
//   P      out  16  product register, updated on the last iteration
//   busy   out  1   high while iterating (CALC)
//   done   out  1   one-cycle pulse in DONE, P valid while high
//
// State table:
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   CALC  | one shift-add iteration per cycle, CNT counts 0..7
//   DONE  | P holds the new product, done pulses for one cycle
//   (11)  | unused code, recovers to IDLE
// ---------------------------------------------------------------------------

// 4-bit carry-lookahead block with group generate/propagate outputs.
module cla4_blk (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       g_grp_o,
    output logic       p_grp_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;

        // Carries fully expanded so no term waits on a lower carry.
        c[0] = c_i;
        c[1] = g[0] | (p[0] & c_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_i);

        s_o     = p ^ c;
        g_grp_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
        p_grp_o = &p;
    end
endmodule

// 8-bit carry-lookahead adder built from two lookahead groups.
module CLA8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Co
);
    logic g_lo;
    logic p_lo;
    logic g_hi;
    logic p_hi;
    logic c4;

    // Upper group carry-in comes from the lower group's lookahead terms,
    // not from a rippled bit-3 carry.
    assign c4 = g_lo | (p_lo & Cin);
    assign Co = g_hi | (p_hi & g_lo) | (p_hi & p_lo & Cin);

    cla4_blk u_lo (
        .a_i     (A[3:0]),
        .b_i     (B[3:0]),
        .c_i     (Cin),
        .s_o     (S[3:0]),
        .g_grp_o (g_lo),
        .p_grp_o (p_lo)
    );

    cla4_blk u_hi (
        .a_i     (A[7:4]),
        .b_i     (B[7:4]),
        .c_i     (c4),
        .s_o     (S[7:4]),
        .g_grp_o (g_hi),
        .p_grp_o (p_hi)
    );
endmodule

module mult8_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    logic [1:0]  state_q;
    logic [1:0]  state_d;

    logic [7:0]  m_q;
    logic [7:0]  m_d;
    logic [7:0]  acc_q;
    logic [7:0]  acc_d;
    logic [7:0]  q_q;
    logic [7:0]  q_d;
    logic [2:0]  cnt_q;
    logic [2:0]  cnt_d;
    logic [15:0] p_q;
    logic [15:0] p_d;

    logic [7:0]  add_b;
    logic [7:0]  sum;
    logic        co;
    logic [15:0] shifted;
    logic        last_iter;

    // Shared adder: partial product added into the high half when the
    // current multiplier LSB is set.
    assign add_b = q_q[0] ? m_q : 8'h00;

    CLA8 u_cla (
        .A   (acc_q),
        .B   (add_b),
        .Cin (1'b0),
        .S   (sum),
        .Co  (co)
    );

    // 17-bit {Co,S,Q} shifted right by one; the carry lands in ACC[7] and
    // Q[0], already consumed, falls off the bottom.
    assign shifted   = {co, sum, q_q[7:1]};
    assign last_iter = (cnt_q == 3'd7);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = start ? ST_CALC : ST_IDLE;
            ST_CALC: state_d = last_iter ? ST_DONE : ST_CALC;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Decoded from the registered state only, so both are glitch-free.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_CALC: busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign P = p_q;

    // ---------------- datapath next values ----------------
    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d   = A;
                    q_d   = B;
                    acc_d = 8'h00;
                    cnt_d = 3'd0;
                end
            end
            ST_CALC: begin
                acc_d = shifted[15:8];
                q_d   = shifted[7:0];
                cnt_d = cnt_q + 3'd1;
                if (last_iter) begin
                    p_d = shifted;
                end
            end
            default: begin
                m_d = m_q;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q   <= 8'h00;
            acc_q <= 8'h00;
            q_q   <= 8'h00;
            cnt_q <= 3'd0;
            p_q   <= 16'h0000;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and swept checks of mult8_seq_ctrl. Inputs change and outputs
// are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mult8_seq_ctrl;
    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int vec_cnt;
    int err_cnt;

    mult8_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Caller must be at a falling edge with the DUT in IDLE. The accept
    // happens on the next rising edge; returns at the falling edge after
    // DONE, from where start can be accepted on the very next edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input string name);
        int busy_n;
        int done_at;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        busy_n  = 0;
        done_at = 0;
        for (int k = 1; k <= 12 && done_at == 0; k++) begin
            if (k > 1) @(negedge clk);
            vec_cnt++;
            if (busy && done) begin
                err_cnt++;
                $display("FAIL %s overlap: busy=%b done=%b at cycle %0d, required not both high",
                         name, busy, done, k);
            end
            if (busy) busy_n++;
            if (done) begin
                done_at = k;
                vec_cnt++;
                if (P !== exp) begin
                    err_cnt++;
                    $display("FAIL %s product: P=%h required %h", name, P, exp);
                end
            end
        end
        vec_cnt++;
        if (done_at !== 9) begin
            err_cnt++;
            $display("FAIL %s latency: done at cycle %0d required 9", name, done_at);
        end
        vec_cnt++;
        if (busy_n !== 8) begin
            err_cnt++;
            $display("FAIL %s busy_len: %0d cycles required 8", name, busy_n);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s idle_after: busy=%b done=%b required 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000) begin
            err_cnt++;
            $display("FAIL reset_state: busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
        end
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        run_op(8'd13, 8'd11, 16'h008F, "13x11");
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (P !== 16'h008F) begin
            err_cnt++;
            $display("FAIL p_hold: P=%h required 008F", P);
        end
    endtask

    task automatic test_boundaries;
        run_op(8'hFF, 8'hFF, 16'hFE01, "FFxFF");
        run_op(8'h00, 8'h5A, 16'h0000, "00x5A");
        run_op(8'h80, 8'h02, 16'h0100, "80x02");
        run_op(8'h01, 8'h80, 16'h0080, "01x80");
        run_op(8'h5A, 8'h00, 16'h0000, "5Ax00");
    endtask

    task automatic test_handshake;
        int dn;
        int done_at;
        A = 8'd3;
        B = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        // Falling edge k sits between rising edges E(k-1) and Ek.
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                dn++;
                vec_cnt++;
                if (P !== 16'h000F) begin
                    err_cnt++;
                    $display("FAIL hs_product: P=%h required 000F", P);
                end
            end
            if (k == 4 || k == 9) begin
                A = 8'hFF;
                B = 8'hFF;
                start = 1'b1;
            end
            if (k == 5) start = 1'b0;
            if (k == 10) begin
                A = 8'd6;
                B = 8'd7;
                start = 1'b1;
            end
        end
        vec_cnt++;
        if (dn !== 1) begin
            err_cnt++;
            $display("FAIL hs_done_count: %0d pulses required 1", dn);
        end
        vec_cnt++;
        if (P !== 16'h000F) begin
            err_cnt++;
            $display("FAIL hs_p_after: P=%h required 000F", P);
        end
        // start held high from E10: accepted, then ignored while in CALC.
        done_at = 0;
        for (int j = 1; j <= 12 && done_at == 0; j++) begin
            @(negedge clk);
            if (j == 5) begin
                vec_cnt++;
                if (P !== 16'h000F || busy !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL hs_held_mid: P=%h busy=%b required 000F 1", P, busy);
                end
            end
            if (done) begin
                done_at = j;
                start = 1'b0;
                vec_cnt++;
                if (P !== 16'h002A) begin
                    err_cnt++;
                    $display("FAIL hs_held_product: P=%h required 002A", P);
                end
            end
        end
        start = 1'b0;
        vec_cnt++;
        if (done_at !== 9) begin
            err_cnt++;
            $display("FAIL hs_held_latency: done at cycle %0d required 9", done_at);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int dn;
        A = 8'd200;
        B = 8'd200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 5; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 16'h0000) begin
            err_cnt++;
            $display("FAIL mid_reset: busy=%b done=%b P=%h required 0 0 0000", busy, done, P);
        end
        rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        vec_cnt++;
        if (dn !== 0) begin
            err_cnt++;
            $display("FAIL mid_reset_quiet: %0d active cycles required 0", dn);
        end
        run_op(8'd7, 8'd9, 16'h003F, "7x9_after_rst");
    endtask

    task automatic test_rst_start_same_edge;
        rst = 1'b1;
        start = 1'b1;
        A = 8'd9;
        B = 8'd9;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0 || P !== 16'h0000) begin
            err_cnt++;
            $display("FAIL rst_start: busy=%b P=%h required 0 0000", busy, P);
        end
        @(negedge clk);
        vec_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_start_idle: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a;
        logic [7:0] b;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(a, b, {8'h00, a} * {8'h00, b}, "sweep");
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        start = 1'b0;
        A = 8'h00;
        B = 8'h00;
        test_reset;
        test_basic;
        test_boundaries;
        test_handshake;
        test_reset_mid_op;
        test_rst_start_same_edge;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
